pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. Generates per-register write enables for IF/ID, ID/EX, EX/MEM and MEM/WB. Also drives PC write, the ID/EX bubble (control bits zeroed) and the IF/ID flush.
- Detects load-use hazards and taken branches resolved in ID.
- Freezes the whole pipeline while data memory is busy, with a watchdog that traps a hung memory.
- Holds the pipeline idle after reset until start_i.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional STALL_STAT_EN build adds stall statistics counters to pipe_hazard_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID operands and the load in ID/EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_ex_memread_i,
    input  logic [4:0] id_ex_rd_i,
    output logic       lu_o
);

    logic w_rd_nonzero;
    logic w_rd_match;

    always_comb begin
        w_rd_nonzero = (id_ex_rd_i != REG_X0);
        w_rd_match   = (id_ex_rd_i == id_rs1_i) || (id_ex_rd_i == id_rs2_i);
        lu_o         = id_ex_memread_i && w_rd_nonzero && w_rd_match;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-freeze watchdog.
// Define STALL_STAT_EN to add the stat_lu_o / stat_frz_o saturating counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_ex_memread_i,
    input  logic [4:0] id_ex_rd_i,
    input  logic       branch_taken_i,
    input  logic       mem_busy_i,
    output logic       pc_write_o,
    output logic       if_id_en_o,
    output logic       if_id_flush_o,
    output logic       id_ex_en_o,
    output logic       id_ex_bubble_o,
    output logic       ex_mem_en_o,
    output logic       mem_wb_en_o,
    output logic       err_o
`ifdef STALL_STAT_EN
    ,
    output logic [31:0] stat_lu_o,
    output logic [31:0] stat_frz_o
`endif
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_err;
    logic             w_err_set;
    logic             w_lu;
    logic             w_live;
    logic             w_frozen;

    load_use_detect u_lu (
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_ex_memread_i (id_ex_memread_i),
        .id_ex_rd_i      (id_ex_rd_i),
        .lu_o            (w_lu)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= r_err | w_err_set;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_state_next = RUN;
            end
            RUN: begin
                if (mem_busy_i) begin
                    w_state_next = FREEZE;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            FREEZE: begin
                if (mem_busy_i) begin
                    if (r_cnt == LP_CNT_LAST) begin
                        w_state_next = ERR;
                        w_err_set    = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
            end
            ERR: begin
                w_state_next = ERR;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A FREEZE release cycle is treated exactly like a non-busy RUN cycle.
    always_comb begin
        w_live         = ((r_state == RUN) || (r_state == FREEZE)) && !mem_busy_i;
        w_frozen       = ((r_state == RUN) || (r_state == FREEZE)) && mem_busy_i;
        pc_write_o     = 1'b0;
        if_id_en_o     = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_en_o     = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        if (w_live) begin
            id_ex_en_o  = 1'b1;
            ex_mem_en_o = 1'b1;
            mem_wb_en_o = 1'b1;
            if (w_lu) begin
                id_ex_bubble_o = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                if_id_en_o    = 1'b1;
                if_id_flush_o = branch_taken_i;
            end
        end
        err_o = r_err;
    end

`ifdef STALL_STAT_EN
    logic [31:0] r_stat_lu;
    logic [31:0] r_stat_frz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_lu  <= '0;
            r_stat_frz <= '0;
        end else begin
            if (id_ex_bubble_o && (r_stat_lu != '1))
                r_stat_lu <= r_stat_lu + 32'd1;
            if (w_frozen && (r_stat_frz != '1))
                r_stat_frz <= r_stat_frz + 32'd1;
        end
    end

    assign stat_lu_o  = r_stat_lu;
    assign stat_frz_o = r_stat_frz;
`else
    logic w_unused_frozen;
    assign w_unused_frozen = w_frozen;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=8).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, mr, br, busy;
    logic [4:0] rs1, rs2, rd;
    logic       pc_w, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en, memwb_en, err;
`ifdef STALL_STAT_EN
    logic [31:0] stat_lu, stat_frz;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(7)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .id_rs1_i        (rs1),
        .id_rs2_i        (rs2),
        .id_ex_memread_i (mr),
        .id_ex_rd_i      (rd),
        .branch_taken_i  (br),
        .mem_busy_i      (busy),
        .pc_write_o      (pc_w),
        .if_id_en_o      (ifid_en),
        .if_id_flush_o   (ifid_fl),
        .id_ex_en_o      (idex_en),
        .id_ex_bubble_o  (idex_bub),
        .ex_mem_en_o     (exmem_en),
        .mem_wb_en_o     (memwb_en),
        .err_o           (err)
`ifdef STALL_STAT_EN
        ,
        .stat_lu_o       (stat_lu),
        .stat_frz_o      (stat_frz)
`endif
    );

    // Output bundle: {pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, err}
    localparam logic [7:0] O_IDLE = 8'b0000_0000;
    localparam logic [7:0] O_RUN  = 8'b1101_0110;
    localparam logic [7:0] O_BR   = 8'b1111_0110;
    localparam logic [7:0] O_LU   = 8'b0001_1110;
    localparam logic [7:0] O_ERR  = 8'b0000_0001;

    typedef struct {
        string      nm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [7:0] outs();
        return {pc_w, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en, memwb_en, err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic m,
                         input logic [4:0] d, input logic t, input logic bz);
        rs1 = a; rs2 = b; mr = m; rd = d; br = t; busy = bz;
    endtask

    // Drive at the falling edge, sample 1 ns later, well before the next rising edge.
    task automatic step_chk(input string nm, input logic [7:0] exp);
        #1;
        chk(nm, {24'd0, outs()}, {24'd0, exp});
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1; drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        step_chk("start_cycle_idle", O_IDLE);
        @(negedge clk); start = 1'b0;
        step_chk("first_run", O_RUN);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"nohaz",        5'd1,  5'd2,  1'b0, 5'd3,  1'b0, O_RUN};
        vecs[1] = '{"lu_rs2_br",    5'd1,  5'd5,  1'b1, 5'd5,  1'b1, O_LU};
        vecs[2] = '{"rd0_nostall",  5'd0,  5'd0,  1'b1, 5'd0,  1'b0, O_RUN};
        vecs[3] = '{"rd0_br",       5'd0,  5'd5,  1'b1, 5'd0,  1'b1, O_BR};
        vecs[4] = '{"lu_rs1",       5'd7,  5'd3,  1'b1, 5'd7,  1'b0, O_LU};
        vecs[5] = '{"nomemread",    5'd7,  5'd7,  1'b0, 5'd7,  1'b0, O_RUN};
        vecs[6] = '{"br_nohaz",     5'd1,  5'd2,  1'b1, 5'd9,  1'b1, O_BR};
        vecs[7] = '{"br_one_cycle", 5'd1,  5'd2,  1'b1, 5'd9,  1'b0, O_RUN};
        vecs[8] = '{"lu_x31",       5'd31, 5'd31, 1'b1, 5'd31, 1'b0, O_LU};
        vecs[9] = '{"nohaz_end",    5'd4,  5'd6,  1'b1, 5'd8,  1'b0, O_RUN};

        rst = 1'b1; start = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        step_chk("reset_idle", O_IDLE);
        @(negedge clk); rst = 1'b0;
        step_chk("idle_ignores_inputs", O_IDLE);
        @(negedge clk); busy = 1'b1;
        step_chk("idle_ignores_busy", O_IDLE);
        busy = 1'b0;
`ifdef STALL_STAT_EN
        chk("stat_lu_reset", stat_lu, 32'd0);
        chk("stat_frz_reset", stat_frz, 32'd0);
`endif

        start_pulse();

        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rd, vecs[i].br, 1'b0);
            step_chk(vecs[i].nm, vecs[i].exp);
        end

        // Three busy cycles, then release with a load-use hazard pending.
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk); drive(5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
            step_chk("freeze_hold", O_IDLE);
        end
        @(negedge clk); busy = 1'b0;
        step_chk("freeze_release_lu", O_LU);
        @(negedge clk); drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
        step_chk("run_after_freeze", O_RUN);
`ifdef STALL_STAT_EN
        chk("stat_lu_count", stat_lu, 32'd4);
        chk("stat_frz_count", stat_frz, 32'd3);
`endif

        // Watchdog: eight busy cycles tolerated, error on the ninth.
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk); busy = 1'b1;
            step_chk("timeout_busy_noerr", O_IDLE);
        end
        @(negedge clk);
        step_chk("timeout_err_rise", O_ERR);
        @(negedge clk); busy = 1'b0; start = 1'b1;
        step_chk("err_sticky_nobusy", O_ERR);
        @(negedge clk); start = 1'b0;
        step_chk("err_sticky_hold", O_ERR);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        step_chk("err_cleared_by_reset", O_IDLE);
        @(negedge clk);
        step_chk("idle_after_err_reset", O_IDLE);

        // Reset during the second FREEZE cycle, with start held to show reset wins.
        start_pulse();
        @(negedge clk); busy = 1'b1;
        step_chk("frz_c1", O_IDLE);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        step_chk("frz_c2", O_IDLE);
        @(negedge clk); rst = 1'b0; start = 1'b0; busy = 1'b0;
        step_chk("reset_mid_freeze_idle", O_IDLE);
`ifdef STALL_STAT_EN
        chk("stat_lu_cleared", stat_lu, 32'd0);
        chk("stat_frz_cleared", stat_frz, 32'd0);
`endif
        @(negedge clk);
        step_chk("still_idle_no_start", O_IDLE);
        start_pulse();
        @(negedge clk); drive(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        step_chk("resume_branch", O_BR);
        @(negedge clk); drive(5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        step_chk("resume_lu", O_LU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
